button_event_decoder: RTL

Classifies the debounced button level into discrete user events: short press, double press, long press and optional auto-repeat. Sits directly downstream of the debouncer and shares its `tick` time base. It converts the level into single-cycle event pulses for the control logic. All timing is counted in `tick` periods, not clock cycles.

---
 rtl/button_event_decoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced button level into single-cycle user events: short press,
// double press, long press and (optionally) auto-repeat while long-held. All
// timing is measured in periods of the shared `tick` strobe, not clock cycles.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   -> repeat_press pulses every REPEAT_TICKS ticks while in LONG
//   undefined -> repeat_press is tied 0 and the repeat logic is not built
//
// Parameters:
//   LONG_TICKS   held duration (ticks) that qualifies as a long press
//   DOUBLE_TICKS max release-to-second-press gap (ticks) for a double press
//   REPEAT_TICKS auto-repeat period (ticks) while long-held
//   CNT_W        tick counter width; tick parameters must lie in 1..2**CNT_W-1
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         one-cycle time-base strobe (same as the debouncer's)
//   debounced    debounced button level, high = pressed
//   short_press  one-cycle pulse: single press, no follow-up within window
//   double_press one-cycle pulse: second press released, or held long
//   long_press   one-cycle pulse: first press held LONG_TICKS ticks
//   repeat_press one-cycle pulse: auto-repeat while long-held
//   held         level, high while the decoder is in the LONG state
// ---------------------------------------------------------------------------
module button_event_decoder #(
    parameter int LONG_TICKS   = 50,
    parameter int DOUBLE_TICKS = 15,
    parameter int REPEAT_TICKS = 10,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic debounced,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic held
);

    // Out-of-range tick parameters would make a threshold unreachable.
    if (LONG_TICKS < 1 || LONG_TICKS > (2**CNT_W) - 1 ||
        DOUBLE_TICKS < 1 || DOUBLE_TICKS > (2**CNT_W) - 1 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > (2**CNT_W) - 1) begin : g_param_check
        $error("button_event_decoder: tick parameters must be in 1..2**CNT_W-1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOWN1,
        S_WAIT2,
        S_DOWN2,
        S_LONG
    } state_t;

    // Compare against N-1: the tick that matches is the N-th tick in the state.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_en;
    logic             short_d, double_d, long_d;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    logic repeat_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state, counter and event decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d  = state_q;
        cnt_en   = 1'b0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        repeat_d = 1'b0;
`endif

        // Level changes are tested before tick thresholds so a release on
        // the threshold tick wins over the timeout.
        unique case (state_q)
            S_IDLE: begin
                if (debounced) state_d = S_DOWN1;
            end
            S_DOWN1: begin
                cnt_en = 1'b1;
                if (!debounced) begin
                    state_d = S_WAIT2;
                end else if (tick && cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_WAIT2: begin
                cnt_en = 1'b1;
                if (debounced) begin
                    state_d = S_DOWN2;
                end else if (tick && cnt_q == DOUBLE_LAST) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_DOWN2: begin
                cnt_en = 1'b1;
                // Both exits report the double press; a held second press
                // does not additionally raise long_press.
                if (!debounced) begin
                    state_d  = S_IDLE;
                    double_d = 1'b1;
                end else if (tick && cnt_q == LONG_LAST) begin
                    state_d  = S_LONG;
                    double_d = 1'b1;
                end
            end
            S_LONG: begin
                if (!debounced) begin
                    state_d = S_IDLE;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    cnt_en = 1'b1;
                    if (tick && cnt_q == REPEAT_LAST) repeat_d = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on every state change and on each repeat.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        end else if (repeat_d) begin
            cnt_d = '0;
`endif
        end else if (tick && cnt_en) begin
            cnt_d = cnt_inc;
        end
    end

    // -----------------------------------------------------------------------
    // State, counter and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: only control state and output flops live here; all of them take
    // the asynchronous reset so a reset aborts any pending event cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            held         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            short_press  <= short_d;
            double_press <= double_d;
            long_press   <= long_d;
            held         <= (state_d == S_LONG);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_press <= 1'b0;
        end else begin
            repeat_press <= repeat_d;
        end
    end
`else
    assign repeat_press = 1'b0;
`endif

endmodule
